// File: rtl/alu_sequencer.sv
// LEG4 machine-cycle controller: 8-phase sequencing, instruction fetch from
// the ROM nibble bus, ALU operand drive, and commit of ACC/CY/index registers.
module alu_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  romData,
    input  logic        testIn,
    input  logic [3:0]  aluResult,
    input  logic        carryOut,
    input  logic        zeroOut,
    output logic [11:0] romAddr,
    output logic        sync,
    output logic [2:0]  cycle,
    output logic [3:0]  aluOp,
    output logic [3:0]  opa,
    output logic [3:0]  accOut,
    output logic        carryFlag
);

    typedef enum logic [2:0] {
        A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
        M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
    } phase_t;

    phase_t      state, state_nxt;
    logic [11:0] pc;
    logic [11:0] pc_inc;
    logic [3:0]  acc;
    logic        cy;
    logic [3:0]  regs [16];
    logic        pending2;
    logic [3:0]  opr, opa_ir;   // instruction register (current byte)
    logic [3:0]  opr1, opa1;    // saved first byte of a 2-byte op
    logic [3:0]  rval;
    logic        two_byte;
    logic        jcn_cond;

    // The ALU zero flag is not needed: JCN compares ACC directly.
    logic unused_zero;
    assign unused_zero = zeroOut;

    assign pc_inc    = pc + 12'd1;
    assign rval      = regs[opa_ir];
    assign two_byte  = (opr == 4'h1) || (opr == 4'h2 && !opa_ir[0]) ||
                       (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7);
    // C1 = invert, C2 = ACC zero, C3 = carry, C4 = TEST low
    assign jcn_cond  = ((opa1[2] && acc == 4'h0) || (opa1[1] && cy) ||
                        (opa1[0] && !testIn)) ^ opa1[3];

    assign romAddr   = pc;
    assign sync      = (state == X3);
    assign cycle     = state;
    assign accOut    = acc;
    assign carryFlag = cy;

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= A1;
        else        state <= state_nxt;
    end

    // Next phase: advance every clock, except stall in A1 while run is low
    always_comb begin
        state_nxt = state;
        if (state != A1 || run)
            state_nxt = phase_t'(state + 3'd1);
    end

    // ALU drive during X1..X3 of a first-byte cycle
    always_comb begin
        aluOp = '0;
        opa   = '0;
        if ((state == X1 || state == X2 || state == X3) && !pending2) begin
            case (opr)
                4'h8: begin aluOp = 4'h8; opa = rval;   end
                4'h9: begin aluOp = 4'h9; opa = rval;   end
                4'hD: begin aluOp = 4'hD; opa = opa_ir; end
                4'hA: begin aluOp = 4'hD; opa = rval;   end
                default: ;
            endcase
        end
    end

    // Fetch latches, PC update and architectural commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            acc      <= '0;
            cy       <= 1'b0;
            pending2 <= 1'b0;
            opr      <= '0;
            opa_ir   <= '0;
            opr1     <= '0;
            opa1     <= '0;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (state == M1) opr    <= romData;
            if (state == M2) opa_ir <= romData;
            if (state == X3) begin
                if (pending2) begin
                    pending2 <= 1'b0;
                    if (opr1 == 4'h4)
                        pc <= {opa1, opr, opa_ir};
                    else if (opr1 == 4'h1 && jcn_cond)
                        pc <= {pc_inc[11:8], opr, opa_ir};
                    else
                        pc <= pc_inc;
                end else begin
                    pc <= pc_inc;
                    if (two_byte) begin
                        pending2 <= 1'b1;
                        opr1     <= opr;
                        opa1     <= opa_ir;
                    end else begin
                        case (opr)
                            4'h8, 4'h9: begin acc <= aluResult; cy <= carryOut; end
                            4'hD, 4'hA: acc <= aluResult;
                            4'hB: begin
                                acc          <= rval;
                                regs[opa_ir] <= acc;
                            end
                            4'h6: regs[opa_ir] <= rval + 4'd1;
                            4'hF: begin
                                case (opa_ir)
                                    4'h0: begin acc <= '0; cy <= 1'b0; end
                                    4'h1: cy <= 1'b0;
                                    4'h3: cy <= ~cy;
                                    4'hA: cy <= 1'b1;
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM and ALU.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  romData;
    logic        testIn;
    logic [3:0]  aluResult;
    logic        carryOut;
    logic        zeroOut;
    logic [11:0] romAddr;
    logic        sync;
    logic [2:0]  cycle;
    logic [3:0]  aluOp;
    logic [3:0]  opa;
    logic [3:0]  accOut;
    logic        carryFlag;

    int checks = 0;
    int fails  = 0;

    logic [7:0] rom [4096];
    logic [7:0] romByte;

    alu_sequencer #(.RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .romData(romData),
        .testIn(testIn), .aluResult(aluResult), .carryOut(carryOut),
        .zeroOut(zeroOut), .romAddr(romAddr), .sync(sync), .cycle(cycle),
        .aluOp(aluOp), .opa(opa), .accOut(accOut), .carryFlag(carryFlag)
    );

    always #5 clk = ~clk;

    // ROM: high nibble (OPR) except during M2, when the low nibble (OPA) is driven
    assign romByte = rom[romAddr];
    assign romData = (cycle == 3'd4) ? romByte[3:0] : romByte[7:4];

    // ALU model: add, subtract with borrow flag, load operand
    always_comb begin
        aluResult = 4'h0;
        carryOut  = 1'b0;
        case (aluOp)
            4'h8: {carryOut, aluResult} = {1'b0, accOut} + {1'b0, opa};
            4'h9: begin aluResult = accOut - opa; carryOut = (accOut < opa); end
            4'hD: aluResult = opa;
            default: ;
        endcase
        zeroOut = (aluResult == 4'h0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic phase_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mc(input int n);
        repeat (8 * n) phase_step();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        phase_step();
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        run = 1'b0; rst_n = 1'b0; testIn = 1'b0;
        repeat (2) phase_step();
        rst_n = 1'b1;
        repeat (3) phase_step();
        checks++;
        if (cycle !== 3'd0 || romAddr !== 12'h000 || accOut !== 4'h0 ||
            carryFlag !== 1'b0 || aluOp !== 4'h0 || sync !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold: cycle=%0d romAddr=%h acc=%h cy=%b aluOp=%h sync=%b, required 0/000/0/0/0/0",
                     cycle, romAddr, accOut, carryFlag, aluOp, sync);
        end
        run = 1'b1;
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (cycle !== 3'(p) || sync !== (p == 7)) begin
                fails++;
                $display("FAIL phase_count: cycle=%0d sync=%b, required %0d/%b", cycle, sync, p, p == 7);
            end
            phase_step();
        end
        repeat (4) phase_step();
        checks++;
        if (cycle !== 3'd4) begin
            fails++;
            $display("FAIL reach_m2: cycle=%0d, required 4", cycle);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cycle !== 3'd0 || romAddr !== 12'h000 || sync !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: cycle=%0d romAddr=%h sync=%b, required 0/000/0", cycle, romAddr, sync);
        end
        phase_step();
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = 8'hD5; rom[1] = 8'hB3; rom[2] = 8'hD9; rom[3] = 8'h83; rom[4] = 8'hB3;
        do_reset();
        mc(3);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (aluOp !== ((p >= 5) ? 4'h8 : 4'h0) || opa !== ((p >= 5) ? 4'h5 : 4'h0)) begin
                fails++;
                $display("FAIL add_drive: phase=%0d aluOp=%h opa=%h, required %h/%h",
                         p, aluOp, opa, (p >= 5) ? 4'h8 : 4'h0, (p >= 5) ? 4'h5 : 4'h0);
            end
            phase_step();
        end
        checks++;
        if (accOut !== 4'hE || carryFlag !== 1'b0) begin
            fails++;
            $display("FAIL add_result: acc=%h cy=%b, required E/0", accOut, carryFlag);
        end
        mc(1);
        checks++;
        if (accOut !== 4'h5) begin
            fails++;
            $display("FAIL xch_reg3: acc=%h, required 5", accOut);
        end
    endtask

    task automatic test_sub();
        clear_rom();
        rom[0] = 8'hD5; rom[1] = 8'hB1; rom[2] = 8'hD3; rom[3] = 8'hF1;
        rom[4] = 8'h91; rom[5] = 8'hF1;
        do_reset();
        mc(2);
        checks++;
        if (accOut !== 4'h0) begin
            fails++;
            $display("FAIL xch_r1: acc=%h, required 0", accOut);
        end
        mc(3);
        checks++;
        if (accOut !== 4'hE || carryFlag !== 1'b1) begin
            fails++;
            $display("FAIL sub_borrow: acc=%h cy=%b, required E/1", accOut, carryFlag);
        end
        mc(1);
        checks++;
        if (accOut !== 4'hE || carryFlag !== 1'b0) begin
            fails++;
            $display("FAIL clc: acc=%h cy=%b, required E/0", accOut, carryFlag);
        end
    endtask

    task automatic test_jun();
        clear_rom();
        rom[12'h000] = 8'h40; rom[12'h001] = 8'h10;
        rom[12'h010] = 8'h4A; rom[12'h011] = 8'hBC;
        do_reset();
        mc(2);
        checks++;
        if (romAddr !== 12'h010) begin
            fails++;
            $display("FAIL jun_010: romAddr=%h, required 010", romAddr);
        end
        mc(2);
        checks++;
        if (romAddr !== 12'hABC) begin
            fails++;
            $display("FAIL jun_abc: romAddr=%h, required ABC", romAddr);
        end
        clear_rom();
        rom[12'h000] = 8'h4F; rom[12'h001] = 8'hFF;
        do_reset();
        mc(2);
        checks++;
        if (romAddr !== 12'hFFF) begin
            fails++;
            $display("FAIL jun_fff: romAddr=%h, required FFF", romAddr);
        end
        mc(1);
        checks++;
        if (romAddr !== 12'h000) begin
            fails++;
            $display("FAIL pc_wrap: romAddr=%h, required 000", romAddr);
        end
    endtask

    task automatic test_jcn();
        // CY clear: JCN on carry falls through to 022
        clear_rom();
        rom[12'h000] = 8'h40; rom[12'h001] = 8'h20;
        rom[12'h020] = 8'h12; rom[12'h021] = 8'h40;
        do_reset();
        mc(4);
        checks++;
        if (romAddr !== 12'h022) begin
            fails++;
            $display("FAIL jcn_cy0: romAddr=%h, required 022", romAddr);
        end
        // STC first, then the same JCN is taken
        rom[12'h000] = 8'hFA; rom[12'h001] = 8'h40; rom[12'h002] = 8'h20;
        do_reset();
        mc(5);
        checks++;
        if (romAddr !== 12'h040 || carryFlag !== 1'b1) begin
            fails++;
            $display("FAIL jcn_cy1: romAddr=%h cy=%b, required 040/1", romAddr, carryFlag);
        end
        // TEST-low condition, both polarities of testIn
        clear_rom();
        rom[12'h000] = 8'h40; rom[12'h001] = 8'h20;
        rom[12'h020] = 8'h11; rom[12'h021] = 8'h40;
        testIn = 1'b0;
        do_reset();
        mc(4);
        checks++;
        if (romAddr !== 12'h040) begin
            fails++;
            $display("FAIL jcn_test0: romAddr=%h, required 040", romAddr);
        end
        testIn = 1'b1;
        do_reset();
        mc(4);
        checks++;
        if (romAddr !== 12'h022) begin
            fails++;
            $display("FAIL jcn_test1: romAddr=%h, required 022", romAddr);
        end
        testIn = 1'b0;
        // Page boundary: byte 2 at 0FF, ACC==0 taken -> page 1
        clear_rom();
        rom[12'h000] = 8'h40; rom[12'h001] = 8'hFE;
        rom[12'h0FE] = 8'h14; rom[12'h0FF] = 8'h37;
        do_reset();
        mc(4);
        checks++;
        if (romAddr !== 12'h137) begin
            fails++;
            $display("FAIL jcn_page: romAddr=%h, required 137", romAddr);
        end
        // Inverted condition -> not taken, sequential increment to 100
        rom[12'h0FE] = 8'h1C;
        do_reset();
        mc(4);
        checks++;
        if (romAddr !== 12'h100) begin
            fails++;
            $display("FAIL jcn_inv: romAddr=%h, required 100", romAddr);
        end
    endtask

    task automatic test_reset_mid_2byte();
        clear_rom();
        rom[12'h000] = 8'h4A; rom[12'h001] = 8'hBC;
        do_reset();
        mc(1);
        checks++;
        if (romAddr !== 12'h001) begin
            fails++;
            $display("FAIL jun_byte1: romAddr=%h, required 001", romAddr);
        end
        repeat (3) phase_step();
        checks++;
        if (cycle !== 3'd3) begin
            fails++;
            $display("FAIL reach_m1: cycle=%0d, required 3", cycle);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (romAddr !== 12'h000 || cycle !== 3'd0) begin
            fails++;
            $display("FAIL mid_reset: romAddr=%h cycle=%0d, required 000/0", romAddr, cycle);
        end
        phase_step();
        rst_n = 1'b1;
        mc(1);
        checks++;
        if (romAddr !== 12'h001) begin
            fails++;
            $display("FAIL fresh_byte1: romAddr=%h, required 001", romAddr);
        end
        mc(1);
        checks++;
        if (romAddr !== 12'hABC) begin
            fails++;
            $display("FAIL fresh_jun: romAddr=%h, required ABC", romAddr);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_jun();
        test_jcn();
        test_reset_mid_2byte();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Machine-cycle controller for the LEG4 ALU: runs the 8-phase machine cycle and owns PC (12b), ACC, CY and the 16x4 index register file.
- Fetches OPR/OPA nibbles from the ROM nibble bus, drives aluOp/opa to the ALU and commits ALU results.
- Handles 1- and 2-byte instructions, with jumps for JUN/JCN; sits between ROM interface and ALU.

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = advance; 0 = hold in A1 (stall)
- romData  in  4  ROM nibble bus, sampled at end of M1 (OPR) and end of M2 (OPA)
- testIn  in  1  TEST pin for JCN
- aluResult  in  4  ALU result
- carryOut  in  1  ALU carry/borrow
- zeroOut  in  1  ALU zero flag (unused for commit; JCN uses the ACC==0 compare)
- romAddr  out  12  current fetch address (= PC)
- sync  out  1  high during X3
- cycle  out  3  phase: A1=0,A2=1,A3=2,M1=3,M2=4,X1=5,X2=6,X3=7
- aluOp  out  4  ALU op code
- opa  out  4  ALU operand
- accOut  out  4  ACC register
- carryFlag  out  1  CY register

Behaviour:
- Reset (async, rst_n=0): cycle=A1, PC=RESET_PC, ACC=0, CY=0, all regs=0, pending2=0, IR=0; outputs: romAddr=RESET_PC, sync=0, aluOp=0, opa=0, accOut=0, carryFlag=0. Reset at any phase aborts the instruction: no commit, second byte discarded.
- Phase FSM: A1->A2->...->X3->A1, one clk per phase. In A1 with run=0, phase holds and no state changes; run is ignored in other phases.
- Fetch: end of M1 latches OPR=romData, end of M2 latches OPA=romData. PC increments mod 4096 on the X3->A1 edge (FFF->000), except when a jump loads PC.
- 2-byte ops (OPR 1 JCN, 2 with OPA[0]=0 FIM, 4 JUN, 5 JMS, 7 ISZ): first byte sets pending2 and saves OPR1/OPA1 at X3. The next machine cycle fetches byte 2 and executes at its X3, then clears pending2. FIM/JMS/ISZ are executed as 2-byte NOPs (byte consumed, no state change).
- ALU drive, X1..X3 only; elsewhere aluOp=0, opa=0:
  - ADD(8R): aluOp=8, opa=reg[R]
  - SUB(9R): aluOp=9, opa=reg[R]
  - LDM(Dn): aluOp=D, opa=n
  - LD(AR): aluOp=D, opa=reg[R]
  - all others: aluOp=0, opa=0
- Commit on the X3->A1 edge:
  - ADD/SUB: ACC<=aluResult, CY<=carryOut
  - LDM/LD: ACC<=aluResult, CY unchanged
  - XCH(BR): ACC<=reg[R] and reg[R]<=ACC, swapped atomically
  - INC(6R): reg[R]<=reg[R]+1 mod 16, CY unchanged
  - F0 CLB: ACC=0, CY=0. F1 CLC: CY=0. F3 CMC: CY=~CY. FA STC: CY=1.
  - Other F-ops and all E-ops: NOP.
- JUN: PC<={OPA1,OPR2,OPA2}.
- JCN, with C1..C4 = OPA1[3:0]:
  - cond = ((C2 & ACC==0) | (C3 & CY) | (C4 & ~testIn)) ^ C1
  - taken: PC<={(PCb2+1)[11:8],OPR2,OPA2}, where PCb2 is the address of byte 2, so a JCN ending on a page boundary targets the next page
  - not taken: PC increments normally
- Condition inputs (ACC, CY, testIn) are sampled at X3 of the byte-2 cycle.
- romAddr always equals PC; it is stable from A1 through X3.

Test Plan:
- Reset/stall: rst_n low mid-M2, release with run=0 -> cycle stays 0, romAddr=000, accOut=0, carryFlag=0, aluOp=0. Raise run -> cycle counts 0..7, sync=1 only at 7.
- Add: ROM 000:D5, 001:B3, 002:D9, 003:83 -> after 4 machine cycles accOut=E, carryFlag=0, reg3=5. aluOp=8, opa=5 during X1..X3 of the 4th cycle.
- Subtract with borrow: ACC=3, CY=0, R1=5, execute 91 -> accOut=E, carryFlag=1. Then F1 -> carryFlag=0, accOut=E.
- JUN: 010:4A, 011:BC -> next fetch romAddr=ABC. An instruction at FFF (1-byte) -> next romAddr=000.
- JCN: CY=1, 020:12, 021:40 -> next romAddr=040. With CY=0 -> next romAddr=022. JCN at 0FE/0FF, taken -> target 1xx.
- Reset mid 2-byte: assert rst_n low in M1 of byte 2 of JUN -> PC=RESET_PC, pending2=0, and the next fetch is decoded as a fresh 1st byte.
